// File: rtl/acc_feeder_if.sv
// Operand/result link between acc_feeder (master) and the accumulator core (slave).
interface acc_feeder_if #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = 16
);
  logic                     run;
  logic                     valid;
  logic [IN_DATA_WIDTH-1:0] number;
  logic                     acc_valid;
  logic [DWIDTH-1:0]        acc_result;

  modport master (output run, valid, number, input acc_valid, acc_result);
  modport slave  (input run, valid, number, output acc_valid, acc_result);
endinterface

// File: rtl/acc_feeder.sv
// Batch sequencer: buffers operands, streams a batch into the accumulator core and
// reports post-minus-pre result. Define ACC_FEEDER_ERR_EN to add the sticky err_o flag.
module acc_feeder #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = 16,
  parameter int DEPTH         = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [IN_DATA_WIDTH-1:0] wr_data_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [DWIDTH-1:0]        result_o,
`ifdef ACC_FEEDER_ERR_EN
  output logic                     err_o,
`endif
  acc_feeder_if.master             core
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                   state_r;
  logic [IN_DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]            wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]            count_r, count_nxt_s, len_r;
  logic                     full_r;
  logic [DWIDTH-1:0]        base_r, result_r;
  logic                     run_r, valid_r, busy_r, done_r;
  logic [IN_DATA_WIDTH-1:0] number_r;
  logic                     push_s, pop_s;

  // FIFO push/pop decisions and next occupancy
  always_comb begin
    push_s      = wr_en_i && !full_r;
    pop_s       = 1'b0;
    count_nxt_s = count_r;
    case (state_r)
      S_IDLE:   pop_s = start_i && (count_r != '0);
      S_STREAM: pop_s = (len_r != CNT_ONE);
      default:  pop_s = 1'b0;
    endcase
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Operand storage; entries are only read after being written, so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
    end
  end

  // Batch sequencer; len_r counts operands still to present including the current one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      len_r    <= '0;
      base_r   <= '0;
      result_r <= '0;
      run_r    <= 1'b0;
      valid_r  <= 1'b0;
      number_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            base_r <= core.acc_result;
            busy_r <= 1'b1;
            run_r  <= 1'b1;
            if (count_r != '0) begin
              len_r    <= count_r;
              valid_r  <= 1'b1;
              number_r <= mem_r[rd_ptr_r];
              state_r  <= S_STREAM;
            end else begin
              len_r    <= '0;
              valid_r  <= 1'b0;
              number_r <= '0;
              state_r  <= S_DRAIN;
            end
          end
        end
        S_STREAM: begin
          if (len_r == CNT_ONE) begin
            valid_r  <= 1'b0;
            number_r <= '0;
            state_r  <= S_DRAIN;
          end else begin
            len_r    <= len_r - CNT_ONE;
            number_r <= mem_r[rd_ptr_r];
          end
        end
        S_DRAIN: begin
          // Core never clears, so the batch sum is the wrapped difference
          result_r <= core.acc_result - base_r;
          run_r    <= 1'b0;
          done_r   <= 1'b1;
          state_r  <= S_DONE;
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          run_r   <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ACC_FEEDER_ERR_EN
  logic err_r;

  // Sticky error: overflow write or missing core valid at drain; new batch clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (wr_en_i && full_r) begin
      err_r <= 1'b1;
    end else if ((state_r == S_DRAIN) && (len_r != '0) && !core.acc_valid) begin
      err_r <= 1'b1;
    end else if ((state_r == S_IDLE) && start_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o = err_r;
`endif

  assign full_o      = full_r;
  assign count_o     = count_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign result_o    = result_r;
  assign core.run    = run_r;
  assign core.valid  = valid_r;
  assign core.number = number_r;

endmodule

// File: tb/tb_acc_feeder.sv
// Self-checking bench for acc_feeder with a behavioural accumulator core model.
module tb_acc_feeder;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        wr_en_i;
  logic [7:0]  wr_data_i;
  logic        full_o;
  logic [3:0]  count_o;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] result_o;
`ifdef ACC_FEEDER_ERR_EN
  logic        err_o;
`endif

  acc_feeder_if #(.IN_DATA_WIDTH(8), .DWIDTH(16)) bus ();

  acc_feeder #(.IN_DATA_WIDTH(8), .DWIDTH(16), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en_i),
    .wr_data_i (wr_data_i),
    .full_o    (full_o),
    .count_o   (count_o),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
`ifdef ACC_FEEDER_ERR_EN
    .err_o     (err_o),
`endif
    .core      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator core model: registered sum, valid cleared when run drops
  logic        core_rst, core_load;
  logic [15:0] core_load_val, core_acc;
  logic        core_valid;
  always_ff @(posedge clk) begin
    if (core_rst) begin
      core_acc   <= 16'h0;
      core_valid <= 1'b0;
    end else if (core_load) begin
      core_acc <= core_load_val;
    end else begin
      if (bus.run && bus.valid) core_acc <= core_acc + {8'h00, bus.number};
      core_valid <= bus.run ? (core_valid | bus.valid) : 1'b0;
    end
  end
  assign bus.acc_valid  = core_valid;
  assign bus.acc_result = core_acc;

  int n_checks = 0;
  int n_errors = 0;
  int model_cnt = 0;
  logic [7:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Push one operand; the bench decides acceptance from its own occupancy model
  task automatic push_op(input logic [7:0] d);
    wr_en_i = 1'b1;
    wr_data_i = d;
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    if (model_cnt < DEPTH) begin
      sb.push_back(d);
      model_cnt++;
    end
    chk("count_after_write", 32'(count_o), 32'(model_cnt));
    chk("full_after_write", 32'(full_o), 32'(model_cnt == DEPTH));
  endtask

  // Start a batch of n operands and follow it through DONE
  task automatic run_batch(input string tag, input int n, input logic [15:0] exp_res);
    bit seen;
    logic [7:0] e;
    seen = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int cyc = 1; cyc <= n + 10 && !seen; cyc++) begin
      if (cyc == 1) begin
        chk({tag, " busy"}, 32'(busy_o), 32'd1);
`ifdef ACC_FEEDER_ERR_EN
        chk({tag, " err_clear"}, 32'(err_o), 32'd0);
`endif
      end
      if (cyc <= n + 1) chk({tag, " valid"}, 32'(valid_o_w), 32'(cyc <= n));
      if (valid_o_w && cyc <= n) begin
        if (sb.size() == 0) begin
          chk({tag, " sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({tag, " number"}, 32'(bus.number), 32'(e));
        end
      end
      if (done_o) begin
        seen = 1'b1;
        chk({tag, " done_cycle"}, 32'(cyc), 32'(n + 2));
        chk({tag, " result"}, 32'(result_o), 32'(exp_res));
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s done_timeout: no done_o within %0d cycles", tag, n + 10);
    end
    model_cnt = model_cnt - n;
  endtask

  logic valid_o_w;
  assign valid_o_w = bus.valid;

  typedef struct {
    logic            core_rst;
    logic            do_load;
    logic [15:0]     preload;
    int              nw;
    logic [8:0][7:0] ops;
    logic [15:0]     exp_res;
    logic [15:0]     exp_core;
    logic            exp_err;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] exp_valid, exp_busy, exp_done, exp_run;
  int done_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 32'd3, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd5, 8'd3},
               16'd15, 16'd15, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 32'd2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20, 8'd10},
               16'd30, 16'd45, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'hFFF0, 32'd1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h20},
               16'h0020, 16'h0010, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0000, 32'd9, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
               16'd36, 16'd36, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 32'd0, 72'h0, 16'd0, 16'd36, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h1234, 32'd5, {8'd0, 8'd0, 8'd0, 8'd0, 8'hAA, 8'h7F, 8'h01, 8'h80, 8'hFF},
               16'h02A9, 16'h14DD, 1'b0};

    reset = 1'b1; core_rst = 1'b1; core_load = 1'b0; core_load_val = 16'h0;
    wr_en_i = 1'b0; wr_data_i = 8'h0; start_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst run", 32'(bus.run), 32'd0);
    chk("rst valid", 32'(bus.valid), 32'd0);
    chk("rst number", 32'(bus.number), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst result", 32'(result_o), 32'd0);
    chk("rst count", 32'(count_o), 32'd0);
    chk("rst full", 32'(full_o), 32'd0);
`ifdef ACC_FEEDER_ERR_EN
    chk("rst err", 32'(err_o), 32'd0);
`endif
    reset = 1'b0; core_rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].core_rst) begin
        core_rst = 1'b1; @(posedge clk); #1; core_rst = 1'b0;
      end
      if (tbl[v].do_load) begin
        core_load = 1'b1; core_load_val = tbl[v].preload;
        @(posedge clk); #1; core_load = 1'b0;
      end
      for (int i = 0; i < tbl[v].nw; i++) push_op(tbl[v].ops[i]);
`ifdef ACC_FEEDER_ERR_EN
      chk($sformatf("v%0d err_pre", v), 32'(err_o), 32'(tbl[v].exp_err));
`endif
      run_batch($sformatf("v%0d", v), model_cnt, tbl[v].exp_res);
      chk($sformatf("v%0d result_held", v), 32'(result_o), 32'(tbl[v].exp_res));
      chk($sformatf("v%0d core_acc", v), 32'(core_acc), 32'(tbl[v].exp_core));
      chk($sformatf("v%0d count_post", v), 32'(count_o), 32'd0);
    end

    // Back-to-back: start held high; the DONE-cycle start is ignored, the IDLE one taken
    exp_valid = 8'b0001_0001;
    exp_run   = 8'b0011_0011;
    exp_busy  = 8'b0111_0111;
    exp_done  = 8'b0100_0100;
    push_op(8'd4);
    start_i = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("b2b c%0d valid", c), 32'(bus.valid), 32'(exp_valid[c-1]));
      chk($sformatf("b2b c%0d run", c), 32'(bus.run), 32'(exp_run[c-1]));
      chk($sformatf("b2b c%0d busy", c), 32'(busy_o), 32'(exp_busy[c-1]));
      chk($sformatf("b2b c%0d done", c), 32'(done_o), 32'(exp_done[c-1]));
      if (c == 1) chk("b2b number1", 32'(bus.number), 32'd4);
      if (c == 5) chk("b2b number2", 32'(bus.number), 32'd6);
      if (c == 3) chk("b2b result1", 32'(result_o), 32'd4);
      if (c == 7) chk("b2b result2", 32'(result_o), 32'd6);
      wr_en_i = (c == 1);
      wr_data_i = 8'd6;
      start_i = (c < 8);
      @(posedge clk); #1;
    end
    wr_en_i = 1'b0; start_i = 1'b0;
    void'(sb.pop_front());
    model_cnt = 0;

    // Reset in STREAM cycle 2 of a 4-operand batch
    push_op(8'd11); push_op(8'd12); push_op(8'd13); push_op(8'd14);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst run", 32'(bus.run), 32'd0);
    chk("midrst valid", 32'(bus.valid), 32'd0);
    chk("midrst number", 32'(bus.number), 32'd0);
    chk("midrst busy", 32'(busy_o), 32'd0);
    chk("midrst count", 32'(count_o), 32'd0);
    chk("midrst full", 32'(full_o), 32'd0);
    chk("midrst result", 32'(result_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done_o) done_cnt++;
    end
    chk("midrst no_done", 32'(done_cnt), 32'd0);
    push_op(8'h42);
    run_batch("post_rst", model_cnt, 16'h0042);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
